// File: rtl/iib_pkg.sv
// Shared constants and types for the integral image builder and its luma stage.
package iib_pkg;

  localparam int unsigned LUMA_R     = 77;
  localparam int unsigned LUMA_G     = 150;
  localparam int unsigned LUMA_B     = 29;
  localparam int unsigned LUMA_SHIFT = 8;

  localparam int unsigned IIB_SUM_W  = 17;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FINISH
  } iib_state_t;

  typedef logic [IIB_SUM_W-1:0] ii_word_t;

endpackage

// File: rtl/luma_convert.sv
// Registered RGB to 8-bit luma, one-cycle latency; the result is truncated, never rounded.
module luma_convert
  import iib_pkg::*;
#(
  parameter int unsigned PIX_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en,
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] g,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] gray
);

  logic [15:0] acc;

  // Weights sum to 256, so full-scale input lands exactly on 255 without overflow.
  always_comb begin
    acc = 16'(LUMA_R) * 16'(r) + 16'(LUMA_G) * 16'(g) + 16'(LUMA_B) * 16'(b);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      gray <= '0;
    end else if (en) begin
      gray <= acc[LUMA_SHIFT +: PIX_W];
    end
  end

endmodule

// File: rtl/integral_image_builder.sv
// Walks the scaler frame in row-major order, converts to luma and builds the
// summed-area image, exposed through a registered read port.
module integral_image_builder
  import iib_pkg::*;
#(
  parameter int unsigned IMG_W  = 20,
  parameter int unsigned IMG_H  = 20,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned SUM_W  = IIB_SUM_W,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  output logic              pix_rd_en,
  output logic [ADDR_W-1:0] pix_rd_addr,
  input  logic [PIX_W-1:0]  pix_r,
  input  logic [PIX_W-1:0]  pix_g,
  input  logic [PIX_W-1:0]  pix_b,
  output logic              busy,
  output logic              ii_done,
  output logic              ii_valid,
  input  logic [ADDR_W-1:0] ii_rd_addr,
  output logic [SUM_W-1:0]  ii_rd_data
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  iib_state_t       state;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             drain_cnt;

  logic [PIX_W-1:0]  gray;
  logic              s1_valid, s2_valid;
  logic [ADDR_W-1:0] s1_addr, s2_addr;
  logic [XW-1:0]     s1_x, s2_x;
  logic              s1_row0, s2_row0;
  logic [SUM_W-1:0]  rs;
  logic [SUM_W-1:0]  ii_sum;

  logic [SUM_W-1:0]  ii_ram   [NPIX];
  logic [SUM_W-1:0]  prev_row [IMG_W];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      pix_rd_en   <= 1'b0;
      pix_rd_addr <= '0;
      busy        <= 1'b0;
      ii_done     <= 1'b0;
      ii_valid    <= 1'b0;
      x           <= '0;
      y           <= '0;
      drain_cnt   <= 1'b0;
    end else begin
      ii_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= FETCH;
            busy        <= 1'b1;
            ii_valid    <= 1'b0;
            pix_rd_en   <= 1'b1;
            pix_rd_addr <= '0;
            x           <= '0;
            y           <= '0;
          end
        end
        FETCH: begin
          if (pix_rd_addr == ADDR_W'(NPIX - 1)) begin
            state       <= DRAIN;
            pix_rd_en   <= 1'b0;
            pix_rd_addr <= '0;
            drain_cnt   <= 1'b0;
          end else begin
            pix_rd_addr <= pix_rd_addr + 1'b1;
          end
          if (x == XW'(IMG_W - 1)) begin
            x <= '0;
            if (y != YW'(IMG_H - 1)) y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state   <= FINISH;
            ii_done <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        FINISH: begin
          state    <= IDLE;
          ii_valid <= 1'b1;
          busy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  luma_convert #(.PIX_W(PIX_W)) u_luma (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (pix_rd_en),
    .r     (pix_r),
    .g     (pix_g),
    .b     (pix_b),
    .gray  (gray)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= pix_rd_en;
      s2_valid <= s1_valid;
    end
  end

  // Stage 2 splits into a row-sum register and a RAM write so the last write lands two cycles after the last fetch.
  always_ff @(posedge CLK) begin
    s1_addr <= pix_rd_addr;
    s1_x    <= x;
    s1_row0 <= (y == '0);
    s2_addr <= s1_addr;
    s2_x    <= s1_x;
    s2_row0 <= s1_row0;
    if (s1_valid) begin
      rs <= ((s1_x == '0) ? '0 : rs) + SUM_W'(gray);
    end
  end

  always_comb begin
    ii_sum = rs + (s2_row0 ? '0 : prev_row[s2_x]);
  end

  always_ff @(posedge CLK) begin
    if (s2_valid) begin
      ii_ram[s2_addr]  <= ii_sum;
      prev_row[s2_x]   <= ii_sum;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ii_rd_data <= '0;
    end else begin
      ii_rd_data <= ii_ram[ii_rd_addr];
    end
  end

endmodule

// File: tb/tb_integral_image_builder.sv
// Directed bench for integral_image_builder with a read-port scoreboard.
module tb_integral_image_builder;

  localparam int unsigned NPIX = 400;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic        pix_rd_en;
  logic [8:0]  pix_rd_addr;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        busy, ii_done, ii_valid;
  logic [8:0]  ii_rd_addr;
  logic [16:0] ii_rd_data;

  logic [7:0]  img_r [NPIX];
  logic [7:0]  img_g [NPIX];
  logic [7:0]  img_b [NPIX];
  int          exp_ii [NPIX];

  typedef struct {
    string tag;
    int    addr;
    int    value;
  } sb_item_t;
  sb_item_t sb_q [$];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  always_comb begin
    pix_r = 8'd0;
    pix_g = 8'd0;
    pix_b = 8'd0;
    if (pix_rd_addr < 9'(NPIX)) begin
      pix_r = img_r[pix_rd_addr];
      pix_g = img_g[pix_rd_addr];
      pix_b = img_b[pix_rd_addr];
    end
  end

  integral_image_builder #(
    .IMG_W  (20),
    .IMG_H  (20),
    .PIX_W  (8),
    .SUM_W  (17),
    .ADDR_W (9)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .start       (start),
    .pix_rd_en   (pix_rd_en),
    .pix_rd_addr (pix_rd_addr),
    .pix_r       (pix_r),
    .pix_g       (pix_g),
    .pix_b       (pix_b),
    .busy        (busy),
    .ii_done     (ii_done),
    .ii_valid    (ii_valid),
    .ii_rd_addr  (ii_rd_addr),
    .ii_rd_data  (ii_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic fill(input int r, input int g, input int b);
    for (int i = 0; i < NPIX; i++) begin
      img_r[i] = 8'(r);
      img_g[i] = 8'(g);
      img_b[i] = 8'(b);
    end
  endtask

  // Reference: per-pixel luma then 2D inclusion-exclusion prefix sum.
  task automatic build_model();
    int gv;
    for (int yy = 0; yy < 20; yy++) begin
      for (int xx = 0; xx < 20; xx++) begin
        int a;
        a  = yy * 20 + xx;
        gv = (77 * int'(img_r[a]) + 150 * int'(img_g[a]) + 29 * int'(img_b[a])) / 256;
        exp_ii[a] = gv;
        if (xx > 0) exp_ii[a] += exp_ii[a - 1];
        if (yy > 0) exp_ii[a] += exp_ii[a - 20];
        if (xx > 0 && yy > 0) exp_ii[a] -= exp_ii[a - 21];
      end
    end
  endtask

  task automatic read_check(input string tag, input int addr);
    sb_item_t it;
    sb_q.push_back('{tag, addr, exp_ii[addr]});
    ii_rd_addr = 9'(addr);
    @(posedge CLK); #1;
    it = sb_q.pop_front();
    check(it.tag, 32'(ii_rd_data), 32'(it.value));
  endtask

  task automatic run_build(input int extra1, input int extra2, input int rst_at,
                           output int done_cnt, output int done_at);
    bit seq_ok;
    int last_n;
    seq_ok   = 1'b1;
    done_cnt = 0;
    done_at  = -1;
    last_n   = (rst_at != 0) ? rst_at : 400;
    start    = 1'b1;
    for (int n = 1; n <= 440; n++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      if (n == 1) check("valid_drop_after_start", 32'(ii_valid), 32'd0);
      if (n <= last_n) begin
        if (!(pix_rd_en === 1'b1 && pix_rd_addr === 9'(n - 1))) seq_ok = 1'b0;
      end
      if (rst_at == 0 && n == 401) check("rd_en_low_after_fetch", 32'(pix_rd_en), 32'd0);
      if (ii_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (n == extra1 || n == extra2) start = 1'b1;
      if (rst_at != 0 && n == rst_at) RESET = 1'b1;
      if (rst_at != 0 && n == rst_at + 1) begin
        RESET = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_en", 32'(pix_rd_en), 32'd0);
        check("abort_valid", 32'(ii_valid), 32'd0);
      end
    end
    check("fetch_addr_sequence", 32'(seq_ok), 32'd1);
    check("busy_low_at_end", 32'(busy), 32'd0);
  endtask

  initial begin
    int dcnt, dat;
    RESET      = 1'b1;
    start      = 1'b0;
    ii_rd_addr = '0;
    fill(0, 0, 0);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_rd_en", 32'(pix_rd_en), 32'd0);
    check("rst_rd_addr", 32'(pix_rd_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(ii_done), 32'd0);
    check("rst_valid", 32'(ii_valid), 32'd0);
    check("rst_rd_data", 32'(ii_rd_data), 32'd0);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // All ones: ii = (x+1)*(y+1)
    fill(1, 1, 1);
    build_model();
    run_build(0, 0, 0, dcnt, dat);
    check("ones_done_count", 32'(dcnt), 32'd1);
    check("ones_done_cycle", 32'(dat), 32'd403);
    check("ones_valid", 32'(ii_valid), 32'd1);
    check("ones_model_399", 32'(exp_ii[399]), 32'd400);
    read_check("ones_ii0", 0);
    read_check("ones_ii19", 19);
    read_check("ones_ii20", 20);
    read_check("ones_ii210", 210);
    read_check("ones_ii399", 399);

    // Full scale: no wrap at the far corner
    fill(255, 255, 255);
    build_model();
    run_build(0, 0, 0, dcnt, dat);
    check("max_done_cycle", 32'(dat), 32'd403);
    read_check("max_ii0", 0);
    read_check("max_ii20", 20);
    read_check("max_ii399", 399);
    check("max_model_399", 32'(exp_ii[399]), 32'd102000);

    // Single bright pixel at origin propagates everywhere
    fill(0, 0, 0);
    img_r[0] = 8'd100; img_g[0] = 8'd100; img_b[0] = 8'd100;
    build_model();
    run_build(0, 0, 0, dcnt, dat);
    read_check("dot_ii0", 0);
    read_check("dot_ii1", 1);
    read_check("dot_ii25", 25);
    read_check("dot_ii399", 399);

    // Red-only pixel at (5,0): gray 76 downstream, 0 elsewhere
    fill(0, 0, 0);
    img_r[5] = 8'd255;
    build_model();
    run_build(0, 0, 0, dcnt, dat);
    read_check("red_ii4", 4);
    read_check("red_ii5", 5);
    read_check("red_ii20", 20);
    read_check("red_ii25", 25);
    read_check("red_ii399", 399);

    // Start re-pulsed while busy and during FINISH
    fill(1, 1, 1);
    build_model();
    run_build(50, 403, 0, dcnt, dat);
    check("repulse_done_count", 32'(dcnt), 32'd1);
    check("repulse_done_cycle", 32'(dat), 32'd403);
    read_check("repulse_ii399", 399);

    // Reset mid-fetch aborts, then a fresh build completes
    fill(2, 2, 2);
    build_model();
    run_build(0, 0, 200, dcnt, dat);
    check("abort_no_done", 32'(dcnt), 32'd0);
    check("abort_valid_stays_low", 32'(ii_valid), 32'd0);
    run_build(0, 0, 0, dcnt, dat);
    check("fresh_done_cycle", 32'(dat), 32'd403);
    check("fresh_valid", 32'(ii_valid), 32'd1);
    read_check("fresh_ii399", 399);
    read_check("fresh_ii21", 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/integral_image_builder.md
Name: integral_image_builder

Overview:
- Downstream consumer of the 20x20 down-scaled RGB frame held by the image scaler stage.
- On a start pulse (the scaler's frame-complete DONE), walks the scaler's read port in row-major order and converts each RGB pixel to 8-bit luma.
- Builds the summed-area (integral) image in internal storage and exposes it through a registered read port for the Haar-feature classifier stage.

Parameters:
- IMG_W, 20, scaled image width in pixels
- IMG_H, 20, scaled image height in pixels
- PIX_W, 8, colour channel width
- SUM_W, 17, integral entry width; must satisfy 2^SUM_W > IMG_W*IMG_H*255 (102000)
- ADDR_W, 9, pixel/integral address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a build (scaler DONE)
- pix_rd_en  out  1  read strobe to scaler
- pix_rd_addr  out  ADDR_W  scaler read address, y*IMG_W+x
- pix_r  in  PIX_W  red from scaler, combinational response to pix_rd_addr
- pix_g  in  PIX_W  green, same timing
- pix_b  in  PIX_W  blue, same timing
- busy  out  1  build in progress
- ii_done  out  1  one-cycle pulse when the integral image is complete
- ii_valid  out  1  integral contents valid for reading
- ii_rd_addr  in  ADDR_W  integral read address, y*IMG_W+x
- ii_rd_data  out  SUM_W  integral value, one-cycle read latency

Behaviour:
- Clock and reset: one clock CLK. Reset is synchronous and active-high on RESET. All ports use these names.
- Reset values: pix_rd_en=0, pix_rd_addr=0, busy=0, ii_done=0, ii_valid=0, ii_rd_data=0. FSM returns to IDLE; pipeline valids clear; integral RAM contents are don't-care.
- FSM states IDLE, FETCH, DRAIN, FINISH:
  - IDLE: start=1 -> FETCH. On the same edge: busy<=1, ii_valid<=0, x/y counters cleared.
  - FETCH: lasts exactly IMG_W*IMG_H cycles.
    - pix_rd_en=1; pix_rd_addr is registered and steps 0..399.
    - RGB is sampled at the end of the cycle in which the address is driven.
    - After address 399 -> DRAIN.
  - DRAIN: 2 cycles to empty the pipeline, then FINISH.
  - FINISH: 1 cycle. ii_done=1, ii_valid<=1, busy<=0. Then -> IDLE.
- Pipeline stage 1 (luma): gray = (77*R + 150*G + 29*B) >> 8. Use a 16-bit intermediate; the result is truncated, never rounded. Max input gives 255.
- Pipeline stage 2 (integral):
  - Row accumulator rs resets to 0 at x=0; rs += gray.
  - ii(x,y) = rs + prev_row[x], where prev_row is an IMG_W x SUM_W line buffer; prev_row[x] is treated as 0 when y=0.
  - Write ii(x,y) into the integral RAM at y*IMG_W+x and into prev_row[x].
  - No overflow is possible given the SUM_W constraint.
- Latency: start accepted in cycle 0; fetches in cycles 1..400; last RAM write in cycle 402; ii_done in cycle 403.
- start while busy: ignored, with no restart and no counter disturbance.
- start coincident with FINISH: ignored. A new start is accepted only in IDLE.
- Read port:
  - ii_rd_data <= RAM[ii_rd_addr] every cycle, independent of state.
  - Data is meaningful only while ii_valid=1. ii_valid drops the cycle after a new start is accepted.
  - ii_rd_addr >= 400: ii_rd_data is don't-care, with no side effects.
- RESET mid-build: abort immediately. No ii_done pulse follows, and ii_valid stays 0 until a full new build completes.
- Counters: x wraps IMG_W-1 -> 0 with y incrementing; y stops at IMG_H-1. Neither counter advances outside FETCH.

Decomposition:
- Package iib_pkg holds:
  - luma weight constants LUMA_R=77, LUMA_G=150, LUMA_B=29 and LUMA_SHIFT=8;
  - the FSM state enum typedef;
  - the SUM_W-wide integral word typedef.
- Sub-module luma_convert: registered RGB->gray, 1-cycle latency, also reused by the classifier debug path.
- Integral RAM and line buffer are inferred inside the top module.

Test Plan:
- All pixels R=G=B=1 (gray=1), pulse start -> ii_done exactly 403 cycles later. ii(x,y)=(x+1)*(y+1), so addr 0 = 1, addr 19 = 20, addr 399 = 400.
- All pixels R=G=B=255 -> gray=255 everywhere. ii(399)=102000 with no wrap; ii(20)=510.
- Only pixel 0 set R=G=B=100, rest 0 -> every ii entry = 100. Pixel R=255 only, G=B=0 -> gray=76, and all entries downstream of it read 76.
- start re-pulsed at cycles 50 and 403 (FINISH) -> both ignored. Exactly one ii_done at 403, and pix_rd_addr sequence 0..399 is uninterrupted.
- RESET asserted at cycle 200 of FETCH -> next cycle busy=0, pix_rd_en=0, ii_valid=0, and no ii_done. A fresh start then completes normally 403 cycles later.
- After completion, read ii_rd_addr=399 -> value appears one cycle later. A second build with a different image drops ii_valid the cycle after its start and reasserts it with new data at its FINISH.
